dds_phase_gen: RTL and testbench
================================

# dds_phase_gen

Phase generator that sits directly upstream of the CORDIC DDS stage and drives its `phase_i` input. A wide phase accumulator is advanced by a frequency control word (FCW) once per enabled cycle. The top DW bits plus a phase offset form the output phase. An optional linear frequency sweep (chirp) engine ramps the FCW. A valid delay line marks the cycle in which the downstream sin/cos outputs correspond to a valid phase.

## Interface
- `DW`, 16: phase output width; matches the downstream CORDIC data width.
- `AW`, 32: accumulator and FCW width; must be ≥ DW.
- `CORDIC_LAT`, 16: downstream latency from phase input to sin/cos output, in cycles (pipeline depth + 2).
- `CW`, 16: sweep length counter width.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset; **asynchronous, active-low**.
- `cfg_valid_i`  in  1  configuration offer.
- `cfg_ready_o`  out  1  configuration accept; transfer occurs when valid & ready at a rising edge.
- `cfg_fcw_i`  in  AW  FCW (unsigned, modulo 2^AW).
- `cfg_pofs_i`  in  DW  phase offset.
- `cfg_mode_i`  in  1  0 = fixed frequency, 1 = sweep.
- `cfg_step_i`  in  AW  per-sample FCW increment, two's complement.
- `cfg_len_i`  in  CW  sweep length in samples.
- `en_i`  in  1  advance enable.
- `sync_clr_i`  in  1  synchronous accumulator clear.
- `phase_o`  out  DW  phase to the CORDIC stage.
- `phase_vld_o`  out  1  `phase_o` is a valid sample.
- `out_vld_o`  out  1  `phase_vld_o` delayed by CORDIC_LAT cycles; aligned with downstream sin/cos.
- `sweep_done_o`  out  1  one-cycle pulse when a sweep completes.
- `busy_o`  out  1  high while in SWEEP.

## Operation
- **States.** IDLE, RUN, SWEEP.
  - Reset enters IDLE.
  - IDLE → RUN on a config handshake with mode=0, or with mode=1 and len=0.
  - IDLE/RUN → SWEEP on a handshake with mode=1 and len>0.
  - SWEEP → RUN after len advances.
  - The block never returns to IDLE except by reset.
- **Handshake.**
  - `cfg_ready_o` = 1 in IDLE and RUN, 0 in SWEEP.
  - On accept: `fcw_cur`←fcw, `pofs`←pofs, `step`←step, `cnt`←len.
  - The accumulator is not cleared on accept, so retuning is phase-continuous.
- **Advance.** An advance occurs in a cycle where state≠IDLE and en_i=1:
  - `acc` ← (`acc` + `fcw_cur`) mod 2^AW.
  - In SWEEP, also `fcw_cur` ← `fcw_cur` + `step` (mod 2^AW) and `cnt` ← `cnt`−1.
  - The advance with `cnt`=1 moves the state to RUN and pulses `sweep_done_o` in the next cycle.
  - After the sweep, RUN holds `fcw_cur` = fcw + len·step.
- **Output.**
  - On every cycle: `phase_o` ← (`acc`[AW-1:AW-DW] + `pofs`) mod 2^DW, using `acc` before that cycle's update.
  - `phase_vld_o` ← advance condition.
  - When en_i=0, `phase_o` still refreshes, but `acc` holds and `phase_vld_o`=0.
- **Clear.**
  - `sync_clr_i`=1 forces `acc`←0 and has priority over advance.
  - `fcw_cur`, `cnt` and state still update as if advancing; the sweep continues.
  - `phase_vld_o` follows the advance condition regardless of clear.
- **Simultaneous events.**
  - A handshake and an advance in the same RUN cycle: the advance uses the old `fcw_cur`; the new values apply from the next cycle.
- **Reset.**
  - Async assertion at any time, including mid-sweep, clears `acc`, `fcw_cur`, `pofs`, `step` and `cnt` to 0, and sets state to IDLE.
  - All outputs go to 0, except `cfg_ready_o`, which is 1 in IDLE.
  - The CORDIC_LAT delay line clears to all zeros.

## Timing
- Config accepted at edge E: first advance using the new FCW is at edge E+1.
- Advance at edge N: `phase_o` and `phase_vld_o` reflect it after edge N. `out_vld_o` follows `phase_vld_o` by exactly CORDIC_LAT cycles.
- First valid sample after start equals `pofs` (`acc`=0).
- `sweep_done_o` is high for exactly one cycle, coincident with the first cycle in RUN; `busy_o` drops in the same cycle.
- Throughput: one phase per cycle; no bubbles other than `en_i` low.

## Configuration
- `DDS_SWEEP_EN` defined:
  - SWEEP state, `step`/`cnt` registers, `busy_o` and `sweep_done_o` are implemented as described.
- Not defined:
  - `cfg_mode_i`, `cfg_step_i` and `cfg_len_i` are ignored; every handshake behaves as mode=0.
  - `cfg_ready_o` is constantly 1 after reset.
  - `busy_o` and `sweep_done_o` are tied to 0.
  - Ports remain present.

## Test plan
- **Basic ramp and wrap.** Reset; load fcw=0x1000_0000, pofs=0, mode=0; en_i=1.
  - → `phase_o` = 0x0000, 0x1000, …, 0xF000, 0x0000 (wrap).
  - → `phase_vld_o`=1 from the edge after the first advance.
- **Offset, retune, en_i gating.** pofs=0x4000, fcw=0x0800_0000.
  - → first sample 0x4000, then 0x4800.
  - Retune to 0x1000_0000 mid-stream → step changes without a phase jump.
  - en_i low for 3 cycles → `acc` holds and `phase_vld_o`=0.
- **Sweep.** (DDS_SWEEP_EN) fcw=0, step=0x0001_0000, len=4.
  - → `phase_o` = 0x0000, 0x0000, 0x0001, 0x0003, 0x0006, then 0x000A, 0x000E, ….
  - → `busy_o` high for 4 advances; `sweep_done_o` one-cycle pulse; `cfg_ready_o`=0 during the sweep.
- **Output alignment.** Toggle en_i → `out_vld_o` equals `phase_vld_o` delayed exactly 16 cycles.
- **Clear priority.** `sync_clr_i` with en_i=1 at fcw=0x1000_0000 → the next two samples are pofs, pofs+0x1000.
- **Reset mid-sweep.** Assert `rst_n` asynchronously mid-sweep.
  - → all outputs 0 immediately, `cfg_ready_o`=1, state IDLE.
  - → no `sweep_done_o` pulse; `out_vld_o`=0 for CORDIC_LAT cycles after restart.

Source files
------------

// File: rtl/dds_phase_gen_if.sv
// Configuration handshake bundle for dds_phase_gen: FCW, phase offset and sweep parameters.
// Master drives the offer; slave (the phase generator) returns cfg_ready_o.
interface dds_phase_gen_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 32,
    parameter int unsigned CW = 16
);
    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic [AW-1:0] cfg_fcw_i;
    logic [DW-1:0] cfg_pofs_i;
    logic          cfg_mode_i;
    logic [AW-1:0] cfg_step_i;
    logic [CW-1:0] cfg_len_i;

    modport master (
        output cfg_valid_i,
        output cfg_fcw_i,
        output cfg_pofs_i,
        output cfg_mode_i,
        output cfg_step_i,
        output cfg_len_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i,
        input  cfg_fcw_i,
        input  cfg_pofs_i,
        input  cfg_mode_i,
        input  cfg_step_i,
        input  cfg_len_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/dds_phase_gen.sv
// DDS phase accumulator feeding a CORDIC stage, with valid delay line for sin/cos alignment.
// Optional linear FCW sweep (chirp) engine enabled by defining DDS_SWEEP_EN.
module dds_phase_gen #(
    parameter int unsigned DW         = 16,
    parameter int unsigned AW         = 32,
    parameter int unsigned CORDIC_LAT = 16,
    parameter int unsigned CW         = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    dds_phase_gen_if.slave cfg,
    input  logic          en_i,
    input  logic          sync_clr_i,
    output logic [DW-1:0] phase_o,
    output logic          phase_vld_o,
    output logic          out_vld_o,
    output logic          sweep_done_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {StIdle, StRun, StSweep} state_e;

    state_e          r_state;
    logic [AW-1:0]   r_acc;
    logic [AW-1:0]   r_fcw;
    logic [DW-1:0]   r_pofs;
    logic [CORDIC_LAT-1:0] r_vld_dly;

    logic w_accept;
    logic w_adv;

    assign w_accept = cfg.cfg_valid_i & cfg.cfg_ready_o;
    assign w_adv    = (r_state != StIdle) & en_i;

`ifdef DDS_SWEEP_EN
    logic [AW-1:0] r_step;
    logic [CW-1:0] r_cnt;
    logic          r_ready;
    logic          r_busy;
    logic          r_done;
    logic          w_sweep_req;

    assign w_sweep_req     = cfg.cfg_mode_i & (cfg.cfg_len_i != '0);
    assign cfg.cfg_ready_o = r_ready;
    assign busy_o          = r_busy;
    assign sweep_done_o    = r_done;
`else
    logic w_unused;

    assign w_unused        = ^{cfg.cfg_mode_i, cfg.cfg_step_i, cfg.cfg_len_i};
    assign cfg.cfg_ready_o = 1'b1;
    assign busy_o          = 1'b0;
    assign sweep_done_o    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_acc       <= '0;
            r_fcw       <= '0;
            r_pofs      <= '0;
            phase_o     <= '0;
            phase_vld_o <= 1'b0;
`ifdef DDS_SWEEP_EN
            r_step      <= '0;
            r_cnt       <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`endif
        end else begin
            // Output uses the accumulator value before this cycle's update.
            phase_o     <= r_acc[AW-1 -: DW] + r_pofs;
            phase_vld_o <= w_adv;

            if (sync_clr_i) begin
                r_acc <= '0;
            end else if (w_adv) begin
                r_acc <= r_acc + r_fcw;
            end

`ifdef DDS_SWEEP_EN
            r_done <= 1'b0;
`endif
            unique case (r_state)
                StIdle, StRun: begin
                    // Accumulator is left untouched so retuning stays phase-continuous.
                    if (w_accept) begin
                        r_fcw  <= cfg.cfg_fcw_i;
                        r_pofs <= cfg.cfg_pofs_i;
`ifdef DDS_SWEEP_EN
                        r_step <= cfg.cfg_step_i;
                        r_cnt  <= cfg.cfg_len_i;
                        if (w_sweep_req) begin
                            r_state <= StSweep;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= StRun;
                        end
`else
                        r_state <= StRun;
`endif
                    end
                end
`ifdef DDS_SWEEP_EN
                StSweep: begin
                    if (w_adv) begin
                        r_fcw <= r_fcw + r_step;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_state <= StRun;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
`endif
                default: r_state <= StIdle;
            endcase
        end
    end

    // Valid delay line matching the downstream CORDIC latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_dly <= '0;
        end else begin
            r_vld_dly[0] <= phase_vld_o;
            for (int i = 1; i < int'(CORDIC_LAT); i++) begin
                r_vld_dly[i] <= r_vld_dly[i-1];
            end
        end
    end

    assign out_vld_o = r_vld_dly[CORDIC_LAT-1];

endmodule

// File: tb/tb_dds_phase_gen.sv
// Scoreboard bench for dds_phase_gen: directed stimulus pushes expected phases, a monitor pops
// them on every valid sample and also tracks out_vld_o against a delayed copy of phase_vld_o.
module tb_dds_phase_gen;

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 32;
    localparam int unsigned LAT = 16;
    localparam int unsigned CW  = 16;
`ifdef DDS_SWEEP_EN
    localparam logic EXP_SWEEP = 1'b1;
`else
    localparam logic EXP_SWEEP = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          en_i       = 1'b0;
    logic          sync_clr_i = 1'b0;
    logic [DW-1:0] phase_o;
    logic          phase_vld_o;
    logic          out_vld_o;
    logic          sweep_done_o;
    logic          busy_o;

    dds_phase_gen_if #(.DW(DW), .AW(AW), .CW(CW)) cfg_if ();

    dds_phase_gen #(
        .DW        (DW),
        .AW        (AW),
        .CORDIC_LAT(LAT),
        .CW        (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg         (cfg_if),
        .en_i        (en_i),
        .sync_clr_i  (sync_clr_i),
        .phase_o     (phase_o),
        .phase_vld_o (phase_vld_o),
        .out_vld_o   (out_vld_o),
        .sweep_done_o(sweep_done_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    logic [LAT-1:0] vld_hist;
    logic [DW-1:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: phase scoreboard plus out_vld_o alignment model.
    always @(negedge clk) begin
        if (!rst_n) begin
            vld_hist = '0;
        end else begin
            check("out_vld_align", {31'd0, out_vld_o}, {31'd0, vld_hist[LAT-1]});
            vld_hist = {vld_hist[LAT-2:0], phase_vld_o};
            if (phase_vld_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_sample: got phase 0x%0h, expected no valid at %0t",
                             phase_o, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("phase", {16'd0, phase_o}, {16'd0, mon_exp});
                end
            end
        end
    end

    task automatic tick(input logic en, input logic push, input logic [DW-1:0] e);
        en_i = en;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input logic [DW-1:0] e);
        tick(1'b1, 1'b1, e);
    endtask

    task automatic hold();
        tick(1'b0, 1'b0, '0);
    endtask

    task automatic set_cfg(input logic [AW-1:0] fcw, input logic [DW-1:0] pofs,
                           input logic mode, input logic [AW-1:0] step, input logic [CW-1:0] len);
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_fcw_i   = fcw;
        cfg_if.cfg_pofs_i  = pofs;
        cfg_if.cfg_mode_i  = mode;
        cfg_if.cfg_step_i  = step;
        cfg_if.cfg_len_i   = len;
        check("cfg_ready_at_offer", {31'd0, cfg_if.cfg_ready_o}, 32'd1);
    endtask

    task automatic drop_cfg();
        cfg_if.cfg_valid_i = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic busy, input logic done,
                                input logic ready);
        check({tag, "_busy"},  {31'd0, busy_o},             {31'd0, busy});
        check({tag, "_done"},  {31'd0, sweep_done_o},       {31'd0, done});
        check({tag, "_ready"}, {31'd0, cfg_if.cfg_ready_o}, {31'd0, ready});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] ph;
        logic [9:0]    pat;
        logic [DW-1:0] swp[4];

        cfg_if.cfg_valid_i = 1'b0;
        cfg_if.cfg_fcw_i   = '0;
        cfg_if.cfg_pofs_i  = '0;
        cfg_if.cfg_mode_i  = 1'b0;
        cfg_if.cfg_step_i  = '0;
        cfg_if.cfg_len_i   = '0;

        // Reset state
        #2;
        check("rst_phase", {16'd0, phase_o}, 32'd0);
        check("rst_phase_vld", {31'd0, phase_vld_o}, 32'd0);
        check("rst_out_vld", {31'd0, out_vld_o}, 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic ramp and wrap; en_i high during the IDLE accept must not advance
        set_cfg(32'h1000_0000, 16'h0000, 1'b0, '0, '0);
        tick(1'b1, 1'b0, '0);
        drop_cfg();
        for (int i = 0; i <= 16; i++) adv(16'(i * 4096));

        // Offset load with clear, then retune mid-stream
        set_cfg(32'h0800_0000, 16'h4000, 1'b0, '0, '0);
        sync_clr_i = 1'b1;
        adv(16'h1000);
        sync_clr_i = 1'b0;
        drop_cfg();
        adv(16'h4000);
        adv(16'h4800);
        adv(16'h5000);
        set_cfg(32'h1000_0000, 16'h4000, 1'b0, '0, '0);
        adv(16'h5800);
        drop_cfg();
        adv(16'h6000);
        adv(16'h7000);
        adv(16'h8000);

        // en_i gating: phase refreshes but holds, no valid
        for (int i = 0; i < 3; i++) begin
            hold();
            check("gate_phase", {16'd0, phase_o}, 32'h9000);
            check("gate_vld", {31'd0, phase_vld_o}, 32'd0);
        end
        adv(16'h9000);
        adv(16'hA000);

        // Clear has priority over advance
        sync_clr_i = 1'b1;
        adv(16'hB000);
        sync_clr_i = 1'b0;
        adv(16'h4000);
        adv(16'h5000);

        // Irregular en_i pattern for out_vld_o alignment, then flush
        pat = 10'b1010001101;
        ph  = 16'h6000;
        for (int i = 0; i < 10; i++) begin
            if (pat[i]) begin
                adv(ph);
                ph = ph + 16'h1000;
            end else begin
                hold();
            end
        end
        for (int i = 0; i < 20; i++) hold();

`ifdef DDS_SWEEP_EN
        // Sweep: fcw=0, step=0x0001_0000, len=4
        set_cfg(32'h0, 16'h0000, 1'b1, 32'h0001_0000, 16'd4);
        sync_clr_i = 1'b1;
        hold();
        sync_clr_i = 1'b0;
        drop_cfg();
        swp[0] = 16'h0000;
        swp[1] = 16'h0000;
        swp[2] = 16'h0001;
        swp[3] = 16'h0003;
        for (int i = 0; i < 4; i++) begin
            check_status("sweep", 1'b1, 1'b0, 1'b0);
            adv(swp[i]);
        end
        check_status("sweep_end", 1'b0, 1'b1, 1'b1);
        adv(16'h0006);
        check_status("post_sweep", 1'b0, 1'b0, 1'b1);
        adv(16'h000A);
        adv(16'h000E);
`else
        // Sweep request is treated as fixed frequency
        set_cfg(32'h0, 16'h0100, 1'b1, 32'h0001_0000, 16'd4);
        sync_clr_i = 1'b1;
        hold();
        sync_clr_i = 1'b0;
        drop_cfg();
        for (int i = 0; i < 4; i++) begin
            check_status("nosweep", 1'b0, 1'b0, 1'b1);
            adv(16'h0100);
        end
`endif

        // Reset in the middle of a sweep (or run in the default build)
        set_cfg(32'h1000_0000, 16'h0000, 1'b1, 32'h0, 16'd10);
        sync_clr_i = 1'b1;
        hold();
        sync_clr_i = 1'b0;
        drop_cfg();
        check("midrun_busy", {31'd0, busy_o}, {31'd0, EXP_SWEEP});
        adv(16'h0000);
        adv(16'h1000);
        adv(16'h2000);
        #5;
        rst_n = 1'b0;
        #1;
        check("arst_phase", {16'd0, phase_o}, 32'd0);
        check("arst_phase_vld", {31'd0, phase_vld_o}, 32'd0);
        check("arst_out_vld", {31'd0, out_vld_o}, 32'd0);
        check_status("arst", 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back in IDLE: en_i alone must not produce samples
        tick(1'b1, 1'b0, '0);
        check("idle_done", {31'd0, sweep_done_o}, 32'd0);
        tick(1'b1, 1'b0, '0);

        // Restart; out_vld_o must stay low for LAT cycles (monitor model)
        set_cfg(32'h1000_0000, 16'h0000, 1'b0, '0, '0);
        tick(1'b1, 1'b0, '0);
        drop_cfg();
        for (int i = 0; i < 20; i++) begin
            check("restart_done", {31'd0, sweep_done_o}, 32'd0);
            adv(16'(i * 4096));
        end
        hold();
        hold();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
